imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 The module SHALL have parameter TAG_W, default 5, width of a sideband tag (e.g. rd) carried alongside each immediate.
REQ-003 The module SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1, upstream has an instruction.
REQ-006 The module SHALL have port in_ready, output, 1, block accepts a transfer this cycle.
REQ-007 The module SHALL have port instr, input, 32, raw instruction word.
REQ-008 The module SHALL have port imm_src, input, 3, format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 reserved.
REQ-009 The module SHALL have port in_tag, input, TAG_W, sideband tag.
REQ-010 The module SHALL have port out_valid, output, 1, imm_ext/out_tag/out_illegal are valid.
REQ-011 The module SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 The module SHALL have port imm_ext, output, XLEN, sign-extended immediate.
REQ-013 The module SHALL have port out_tag, output, TAG_W, tag of the same transfer.
REQ-014 The module SHALL have port out_illegal, output, 1, imm_src was reserved.

Function
REQ-015 The block SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-016 The immediates SHALL be formed as follows, all sign-extended from instr[31] to XLEN:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-017 For a reserved imm_src, the block SHALL output imm_ext = 0 with out_illegal = 1; for every other value, out_illegal SHALL be 0.
REQ-018 Latency SHALL be 1 cycle: an accepted input SHALL appear on the outputs in the next cycle at the earliest.
REQ-019 Transfers SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-020 While out_valid = 1 and out_ready = 0, imm_ext, out_tag and out_illegal SHALL hold stable.
REQ-021 Once out_valid is asserted, it SHALL not deassert until the output transfer completes.
REQ-022 Simultaneous input and output transfers SHALL sustain 1 transfer per cycle.

Reset
REQ-023 When rst = 1 at a clock edge, the block SHALL clear all storage:
- out_valid = 0, imm_ext = 0, out_tag = 0, out_illegal = 0.
- Skid buffer (if present) empty.
REQ-024 While rst = 1, in_ready SHALL be 0; it SHALL return to 1 in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-stream SHALL discard all held transfers, with no output transfer in the reset cycle.

Configuration
REQ-026 The block SHALL support a compile-time macro IMM_GEN_PIPE_SKID_EN.
REQ-027 With IMM_GEN_PIPE_SKID_EN defined, the block SHALL include a one-entry skid buffer behind the output register:
- in_ready is a registered signal equal to "skid empty" and is independent of out_ready in the same cycle.
- An input accepted while the output is stalled goes into the skid.
- When the output transfers, a full skid moves into the output register, and in_ready rises the following cycle.
REQ-028 Without IMM_GEN_PIPE_SKID_EN, the block SHALL have a single output register only, with in_ready = !out_valid || out_ready (combinational path from out_ready).
REQ-029 Both variants SHALL satisfy REQ-015 to REQ-025.

Verification
REQ-030 The bench SHALL cover: XLEN=32, I, instr 0xFFF00093 -> imm_ext 0xFFFFFFFF; S, 0xFE112E23 -> 0xFFFFFFFC; each with out_illegal = 0 and latency 1.
REQ-031 The bench SHALL cover: XLEN=32, B, 0xFE000CE3 -> 0xFFFFFFF8; U, 0x123450B7 -> 0x12345000; J, 0x001000EF -> 0x00000800.
REQ-032 The bench SHALL cover: XLEN=64, U, 0x800000B7 -> 0xFFFFFFFF80000000; I, 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
REQ-033 The bench SHALL cover: imm_src = 110 with any instr -> imm_ext 0, out_illegal 1, in_tag passed unchanged to out_tag.
REQ-034 The bench SHALL cover: IMM_GEN_PIPE_SKID_EN defined, streaming tags 1..4 with out_ready low for cycles 2-4:
- Tag 2 enters the skid; in_ready drops the next cycle.
- Outputs appear in order 1, 2, 3, 4 with no loss and no repeat.
- Same stream without the macro: identical output order, with in_ready low while stalled.
REQ-035 The bench SHALL cover: rst pulsed for 1 cycle while the output and skid are both full -> out_valid 0 in the following cycle, in_ready 1 one cycle after reset deasserts, and no stale tag ever emitted.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator (I/S/B/U/J) behind a valid/ready output register.
// Define IMM_GEN_PIPE_SKID_EN to add a one-entry skid buffer that makes in_ready registered.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] SrcI = 3'b000;
  localparam logic [2:0] SrcS = 3'b001;
  localparam logic [2:0] SrcB = 3'b010;
  localparam logic [2:0] SrcU = 3'b011;
  localparam logic [2:0] SrcJ = 3'b100;

  // ---------------------------------------------------------------------------
  // Immediate formation
  // ---------------------------------------------------------------------------
  logic [31:0]     gen_imm32;
  logic [XLEN-1:0] gen_imm;
  logic            gen_ill;
  logic            unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    gen_imm32 = '0;
    gen_ill   = 1'b0;
    case (imm_src)
      SrcI:    gen_imm32 = {{20{instr[31]}}, instr[31:20]};
      SrcS:    gen_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SrcB:    gen_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8],
                            1'b0};
      SrcU:    gen_imm32 = {instr[31:12], 12'b0};
      SrcJ:    gen_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
      default: gen_ill   = 1'b1;
    endcase
  end

  if (XLEN > 32) begin : g_wide
    assign gen_imm = {{(XLEN-32){gen_imm32[31]}}, gen_imm32};
  end else begin : g_narrow
    assign gen_imm = gen_imm32[XLEN-1:0];
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_ill_q, out_ill_d;

  assign accept      = in_valid && in_ready;
  // Masked during reset so nothing can transfer out in the reset cycle.
  assign out_valid   = out_valid_q && !rst;
  assign imm_ext     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;

`ifdef IMM_GEN_PIPE_SKID_EN

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;

  // Registered ready: only depends on skid occupancy, never on out_ready.
  assign in_ready = !rst && !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // Skid full implies no accept this cycle, so the skid entry is the only candidate.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_imm_d = gen_imm;
          out_tag_d = in_tag;
          out_ill_d = gen_ill;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = gen_imm;
      skid_tag_d   = in_tag;
      skid_ill_d   = gen_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

`else

  assign in_ready = !rst && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_tag_d   = out_tag_q;
    out_ill_d   = out_ill_q;
    if (!out_valid_q || out_ready) begin
      out_valid_d = accept;
      if (accept) begin
        out_imm_d = gen_imm;
        out_tag_d = in_tag;
        out_ill_d = gen_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_tag_q   <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_tag_q   <= out_tag_d;
      out_ill_q   <= out_ill_d;
    end
  end

`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, out_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready32, out_valid32, ill32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] tag32;
  logic             in_ready64, out_valid64, ill64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_ext(imm32), .out_tag(tag32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_ext(imm64), .out_tag(tag64), .out_illegal(ill64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t             q[$];
  logic [TAG_W-1:0] emitted[$];

  // Immediates derived with arithmetic shifts on the sign-extended word.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                 input logic [TAG_W-1:0] tag);
    logic signed [63:0] sx;
    logic signed [63:0] top;
    exp_t e;
    sx    = 64'($signed(ins));
    e.tag = tag;
    e.ill = 1'b0;
    e.imm = '0;
    case (src)
      3'd0: e.imm = sx >>> 20;
      3'd1: begin
        top   = sx >>> 25;
        e.imm = (top << 5) | 64'(ins[11:7]);
      end
      3'd2: begin
        top   = sx >>> 31;
        e.imm = (top << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) |
                (64'(ins[11:8]) << 1);
      end
      3'd3: e.imm = sx & ~64'hFFF;
      3'd4: begin
        top   = sx >>> 31;
        e.imm = (top << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) |
                (64'(ins[30:21]) << 1);
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  logic exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready32", in_ready32, 0);
      chk("rst_in_ready64", in_ready64, 0);
      chk("rst_out_valid32", out_valid32, 0);
      chk("rst_out_valid64", out_valid64, 0);
      q.delete();
    end else begin
`ifdef IMM_GEN_PIPE_SKID_EN
      exp_ready = (q.size() < 2);
`else
      exp_ready = (q.size() == 0) || out_ready;
`endif
      chk("in_ready32", in_ready32, exp_ready);
      chk("in_ready64", in_ready64, exp_ready);
      chk("out_valid32", out_valid32, q.size() != 0);
      chk("out_valid64", out_valid64, q.size() != 0);
      if (q.size() != 0) begin
        chk("imm32", imm32, q[0].imm[31:0]);
        chk("imm64", imm64, q[0].imm);
        chk("tag32", tag32, q[0].tag);
        chk("tag64", tag64, q[0].tag);
        chk("ill32", ill32, q[0].ill);
        chk("ill64", ill64, q[0].ill);
      end
      if (out_valid32 && out_ready && q.size() != 0) begin
        emitted.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (in_valid && in_ready32) q.push_back(model(instr, imm_src, in_tag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer into an idle pipe, checked against literals one cycle after acceptance.
  task automatic lit(input string name, input logic [31:0] ins, input logic [2:0] src,
                     input logic [TAG_W-1:0] tag, input logic [63:0] e64, input logic e_ill);
    in_valid  = 1'b1;
    instr     = ins;
    imm_src   = src;
    in_tag    = tag;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk({name, "_valid"}, out_valid32, 1);
    chk({name, "_imm32"}, imm32, e64[31:0]);
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_tag"}, tag32, tag);
    chk({name, "_ill32"}, ill32, e_ill);
    chk({name, "_ill64"}, ill64, e_ill);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int          nt;
  int          idx;
  logic        rdy_hist[0:15];
  logic [31:0] tv_instr[0:7];
  logic [2:0]  tv_src[0:7];
  logic [15:0] rpat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    imm_src   = '0;
    in_tag    = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid32, 0);
    chk("reset_imm32", imm32, 0);
    chk("reset_imm64", imm64, 0);
    chk("reset_tag", tag32, 0);
    chk("reset_ill", ill32, 0);
    chk("reset_in_ready", in_ready32, 1);

    lit("i_neg1", 32'hFFF00093, 3'b000, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    lit("s_neg4", 32'hFE112E23, 3'b001, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    lit("b_neg8", 32'hFE000CE3, 3'b010, 5'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    lit("u_pos", 32'h123450B7, 3'b011, 5'd4, 64'h0000_0000_1234_5000, 1'b0);
    lit("j_800", 32'h001000EF, 3'b100, 5'd5, 64'h0000_0000_0000_0800, 1'b0);
    lit("u_neg", 32'h800000B7, 3'b011, 5'd6, 64'hFFFF_FFFF_8000_0000, 1'b0);
    lit("rsv110", 32'hFFFF_FFFF, 3'b110, 5'h15, 64'h0, 1'b1);

    // Stream tags 1..4 with the output stalled in cycles 2-4.
    emitted.delete();
    nt = 1;
    for (int c = 1; c <= 12; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (nt <= 4);
      in_tag    = nt[TAG_W-1:0];
      instr     = 32'h8765_4321 ^ (nt * 32'h0101_0100);
      imm_src   = nt[2:0];
      #1;
      rdy_hist[c] = in_ready32;
      if (in_valid && in_ready32) nt++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef IMM_GEN_PIPE_SKID_EN
    chk("skid_take_tag2", rdy_hist[2], 1);
    chk("skid_ready_drop3", rdy_hist[3], 0);
    chk("skid_ready_drop4", rdy_hist[4], 0);
    chk("skid_ready_late5", rdy_hist[5], 0);
    chk("skid_ready_back6", rdy_hist[6], 1);
`else
    chk("plain_stall_ready2", rdy_hist[2], 0);
    chk("plain_stall_ready3", rdy_hist[3], 0);
    chk("plain_stall_ready4", rdy_hist[4], 0);
    chk("plain_ready5", rdy_hist[5], 1);
`endif
    chk("stream_accepted", nt, 5);
    chk("stream_count", emitted.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < emitted.size()) chk("stream_order", emitted[i], i + 1);
    end

    // Reset while holding data: output full (and skid full when present).
    emitted.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_src   = 3'b000;
    instr     = 32'h0070_0093;
    in_tag    = 5'd7;
    tick();
    in_tag = 5'd8;
    tick();
    in_valid = 1'b0;
`ifdef IMM_GEN_PIPE_SKID_EN
    chk("pre_rst_skid_full", in_ready32, 0);
`endif
    chk("pre_rst_out_valid", out_valid32, 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", out_valid32, 0);
    chk("post_rst_in_ready", in_ready32, 1);
    repeat (4) tick();
    chk("no_stale_tag", emitted.size(), 0);

    // Directed burst with an irregular out_ready pattern.
    tv_instr = '{32'hFFF00093, 32'h7FF00013, 32'hFE112E23, 32'h00112623,
                 32'hFE000CE3, 32'h800000B7, 32'h801FF06F, 32'hABCDEF01};
    tv_src   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd7};
    rpat     = 16'b1011_0010_1110_0101;
    emitted.delete();
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready = rpat[c % 16];
      in_valid  = 1'b1;
      instr     = tv_instr[idx];
      imm_src   = tv_src[idx];
      in_tag    = 5'(idx + 10);
      #1;
      if (in_ready32) idx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("burst_accepted", idx, 8);
    for (int c = 0; c < 10 && out_valid32; c++) tick();
    chk("burst_drained", out_valid32, 0);
    chk("burst_count", emitted.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < emitted.size()) chk("burst_order", emitted[i], i + 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
